modm_dn_cnt: RTL and testbench
==============================

Name: modm_dn_cnt

Overview:
- Programmable mod-M down counter with parallel preset; the down-counting counterpart of the team's mod-M up counter.
- Counts M-1 → 0, then wraps to M-1 (free-run) or stops at 0 (one-shot).
- Emits a terminal-count pulse and a done flag, for timeouts, dividers and cascaded prescalers.
- Count enable is registered one cycle before use, matching the up counter's enable timing.

Parameters:
- M, 11, modulus; legal range 2..2**W; values outside this range are an elaboration error.
- W, 4, counter width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- x  input  1  count enable request; registered into cnt_r before use.
- ld  input  1  synchronous load strobe; not registered.
- d  input  W  preset value used when ld=1.
- oneshot  input  1  1 = stop at 0; 0 = wrap to M-1.
- q  output  W  current count.
- tc  output  1  registered terminal-count pulse.
- done  output  1  high while the FSM is in DONE.
- zero  output  1  combinational, (q==0).

Behaviour:
- Reset (clr=1, asynchronous): q=0, cnt_r=0, tc=0, state=RUN, done=0. zero=1 follows q.
- cnt_r <= x on every edge. x first high at edge k produces the first decrement at edge k+1. x low at edge k stops decrementing from edge k+1.
- Priority at each edge: clr > ld > count > hold.
- ld=1:
  - q <= d if d < M; otherwise q <= M-1 (clamped).
  - state <= RUN. tc <= 0.
  - Takes effect in the same edge, regardless of cnt_r or state.
- FSM states: RUN and DONE.
- RUN, cnt_r=1, q!=0: q <= q-1, tc <= 0.
- RUN, cnt_r=1, q==0, oneshot=0: q <= M-1, tc <= 1 (wrap).
- RUN, cnt_r=1, q==0, oneshot=1: q stays 0, tc <= 1, state <= DONE.
- RUN, cnt_r=0: q holds, tc <= 0.
- DONE: q holds at 0, cnt_r is ignored, tc <= 0. Only ld or clr exits DONE.
- tc is high for exactly one clk cycle per terminal event.
- oneshot is sampled only at the edge where q==0 and cnt_r=1; changing it mid-count has no other effect.
- Simultaneous ld and terminal condition: ld wins; no tc, no DONE entry.
- Arithmetic is W bits. q never exceeds M-1 after any load or wrap. The up counter's natural 2**W wrap is not used.
- clr asserted mid-count or in DONE: immediate return to reset values. cnt_r is cleared, so x must be seen high again, giving one cycle of enable latency after clr deasserts.

Optional Feature:
- Macro: MODM_DN_BORROW_EN.
- Defined: adds output port "borrow", 1 bit, combinational = cnt_r & (q==0) & (state==RUN) & ~ld. Lets a higher-order stage be enabled in the same cycle, for zero-latency cascading.
- Not defined: port absent. Cascading uses tc, which adds one cycle of latency per stage.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then x=0 for 3 cycles → q=0, zero=1, tc=0, done=0.
- M=11, ld with d=5, then x=1 held, oneshot=0 → q sequence 5,5,4,3,2,1,0,10,9 (one-cycle enable latency); tc high one cycle coincident with q=10.
- Load d=13 → q=10 (clamped to M-1).
- oneshot=1, ld d=2, x=1 held → q 2,2,1,0,0...; tc pulses once; done=1 and stays high with x=1. Then ld d=7 → q=7, done=0.
- With q=0 and cnt_r=1, assert ld d=3 in the same cycle → q=3, tc=0, done=0.
- Assert clr mid-count at q=6 → q=0 immediately. After release with x=1, q wraps to 10 one edge later than x rises. With MODM_DN_BORROW_EN defined, borrow=1 exactly in the cycle where q=0 and cnt_r=1.

Source files
------------

// File: rtl/modm_dn_cnt.sv
// -----------------------------------------------------------------------------
// modm_dn_cnt -- programmable mod-M down counter with parallel preset.
//
// Counts M-1 down to 0. At 0 it either wraps back to M-1 (free-run) or parks
// at 0 in the DONE state (one-shot). A registered terminal-count pulse and a
// done flag are provided for timeouts, dividers and cascaded prescalers. The
// count enable is registered one cycle before use, so its timing matches the
// mod-M up counter.
//
// Parameters:
//   M        modulus, legal range 2 .. 2**W
//   W        counter width in bits
//
// Ports:
//   clk      clock, rising-edge
//   clr      asynchronous active-high reset
//   x        count enable request (registered into cnt_r before use)
//   ld       synchronous load strobe (used directly, not registered)
//   d        preset value; values >= M are clamped to M-1
//   oneshot  1 = stop at 0 and enter DONE, 0 = wrap to M-1
//   q        current count
//   tc       registered terminal-count pulse, one cycle per terminal event
//   done     high while in DONE
//   zero     combinational (q == 0)
//   borrow   (only with MODM_DN_BORROW_EN) combinational terminal condition,
//            for zero-latency enable of a higher-order stage
//
// Build option: define MODM_DN_BORROW_EN to add the borrow output.
// -----------------------------------------------------------------------------
module modm_dn_cnt #(
  parameter int M = 11,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         x,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         oneshot,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         done,
  output logic         zero
`ifdef MODM_DN_BORROW_EN
  ,
  output logic         borrow
`endif
);

  if (M < 2 || M > (1 << W)) begin : g_bad_m
    $error("modm_dn_cnt: M=%0d outside legal range 2..2**W (W=%0d)", M, W);
  end

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [W-1:0] Q_MAX = W'(M - 1);
  // One extra bit so that M == 2**W is representable in the clamp compare.
  localparam logic [W:0]   M_EXT = (W + 1)'(M);

  logic [W-1:0] q_q, q_d;
  logic         cnt_q, cnt_d;     // cnt_r: enable registered one cycle early
  logic         tc_q, tc_d;
  logic [0:0]   state_q, state_d;

  logic [W-1:0] load_val;
  logic         at_zero;
  logic         terminal;

  assign load_val = ({1'b0, d} < M_EXT) ? d : Q_MAX;
  assign at_zero  = (q_q == '0);
  // Terminal event: an enabled count reaching 0 while running, unless a load
  // pre-empts it in the same edge.
  assign terminal = cnt_q & at_zero & (state_q == ST_RUN) & ~ld;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the if/else tree can leave it unassigned and infer a latch.
    cnt_d   = x;
    q_d     = q_q;
    tc_d    = 1'b0;
    state_d = state_q;

    if (ld) begin
      q_d     = load_val;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && cnt_q) begin
      if (!at_zero) begin
        q_d = q_q - 1'b1;
      end else begin
        tc_d = 1'b1;
        if (oneshot) begin
          state_d = ST_DONE;           // q stays at 0
        end else begin
          q_d = Q_MAX;
        end
      end
    end
    // DONE without ld: hold at 0, cnt_r ignored.
  end

  // NOTE: clr is asynchronous, so it sits in the sensitivity list and every
  // flop is forced to its reset value the moment clr rises.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q     <= '0;
      cnt_q   <= 1'b0;
      tc_q    <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the values
      // present before the edge, independent of statement order.
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign done = (state_q == ST_DONE);
  assign zero = at_zero;

`ifdef MODM_DN_BORROW_EN
  assign borrow = terminal;
`else
  logic unused_terminal;
  assign unused_terminal = terminal;
`endif

endmodule

// File: tb/tb_modm_dn_cnt.sv
module tb_modm_dn_cnt;
  localparam int M = 11;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr, x, ld, oneshot;
  logic [W-1:0] d;
  wire  [W-1:0] q;
  wire          tc, done, zero;
`ifdef MODM_DN_BORROW_EN
  wire          borrow;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model: count value, pending enable, done flag, tc pulse.
  int m_q;
  bit m_en, m_done, m_tc;

  always #5 clk = ~clk;

  modm_dn_cnt #(.M(M), .W(W)) dut (
    .clk     (clk),
    .clr     (clr),
    .x       (x),
    .ld      (ld),
    .d       (d),
    .oneshot (oneshot),
    .q       (q),
    .tc      (tc),
    .done    (done),
`ifdef MODM_DN_BORROW_EN
    .borrow  (borrow),
`endif
    .zero    (zero)
  );

  task automatic model_reset();
    m_q = 0; m_en = 0; m_done = 0; m_tc = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int prev;
    prev = m_q;
    m_tc = 0;
    if (ld) begin
      m_q    = (int'(d) >= M) ? M - 1 : int'(d);
      m_done = 0;
    end else if (m_en && !m_done) begin
      if (prev == 0 && oneshot) begin
        m_done = 1;
        m_tc   = 1;
      end else begin
        m_q  = (prev + M - 1) % M;
        m_tc = (prev == 0);
      end
    end
    m_en = x;
  endtask

  // Drive one cycle of inputs, advance model, return 1 time unit after edge.
  task automatic step(input bit xi, input bit ldi, input int di, input bit osi);
    x = xi; ld = ldi; d = W'(di); oneshot = osi;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; x = 0; ld = 0; d = '0; oneshot = 0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (q !== 4'd0 || zero !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin
        n_fails++;
        $display("FAIL reset[%0d]: q=%0d zero=%b tc=%b done=%b want q=0 zero=1 tc=0 done=0",
                 i, q, zero, tc, done);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_q[9];
    bit exp_tc[9];
    exp_q  = '{5, 5, 4, 3, 2, 1, 0, 10, 9};
    exp_tc = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    step(0, 1, 5, 0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(1, 0, 0, 0);
      n_checks++;
      if (q !== W'(exp_q[i]) || tc !== exp_tc[i]) begin
        n_fails++;
        $display("FAIL wrap[%0d]: q=%0d tc=%b want q=%0d tc=%b", i, q, tc, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_clamp();
    int dv[4];
    int ev[4];
    dv = '{13, 15, 10, 0};
    ev = '{10, 10, 10, 0};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, dv[i], 0);
      n_checks++;
      if (q !== W'(ev[i])) begin
        n_fails++;
        $display("FAIL clamp d=%0d: q=%0d want %0d", dv[i], q, ev[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_q[7];
    bit exp_tc[7];
    bit exp_dn[7];
    exp_q  = '{2, 2, 1, 0, 0, 0, 0};
    exp_tc = '{0, 0, 0, 0, 1, 0, 0};
    exp_dn = '{0, 0, 0, 0, 1, 1, 1};
    step(0, 1, 2, 1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1, 0, 0, 1);
      n_checks++;
      if (q !== W'(exp_q[i]) || tc !== exp_tc[i] || done !== exp_dn[i]) begin
        n_fails++;
        $display("FAIL oneshot[%0d]: q=%0d tc=%b done=%b want q=%0d tc=%b done=%b",
                 i, q, tc, done, exp_q[i], exp_tc[i], exp_dn[i]);
      end
    end
    step(1, 1, 7, 1);
    n_checks++;
    if (q !== 4'd7 || done !== 1'b0 || tc !== 1'b0) begin
      n_fails++;
      $display("FAIL oneshot_reload: q=%0d done=%b tc=%b want q=7 done=0 tc=0", q, done, tc);
    end
  endtask

  task automatic test_ld_priority();
    // Count down with enable held until q==0 and cnt_r==1, then load.
    for (int i = 0; i < 16 && !(m_q == 0 && m_en); i++) step(1, 0, 0, 1);
    n_checks++;
    if (q !== 4'd0) begin
      n_fails++;
      $display("FAIL ld_prio_setup: q=%0d want 0", q);
    end
    step(1, 1, 3, 1);
    n_checks++;
    if (q !== 4'd3 || tc !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL ld_priority: q=%0d tc=%b done=%b want q=3 tc=0 done=0", q, tc, done);
    end
  endtask

  task automatic test_clr_midcount();
    step(0, 1, 9, 0);
    for (int i = 0; i < 16 && m_q != 6; i++) step(1, 0, 0, 0);
    clr = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if (q !== 4'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL clr_async: q=%0d tc=%b done=%b want q=0 tc=0 done=0", q, tc, done);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    x = 1'b1; ld = 1'b0; oneshot = 1'b0;
`ifdef MODM_DN_BORROW_EN
    #1;
    n_checks++;
    if (borrow !== 1'b0) begin
      n_fails++;
      $display("FAIL borrow_after_clr: borrow=%b want 0", borrow);
    end
`endif
    step(1, 0, 0, 0);
    n_checks++;
    if (q !== 4'd0 || tc !== 1'b0) begin
      n_fails++;
      $display("FAIL clr_latency: q=%0d tc=%b want q=0 tc=0", q, tc);
    end
`ifdef MODM_DN_BORROW_EN
    n_checks++;
    if (borrow !== 1'b1) begin
      n_fails++;
      $display("FAIL borrow_terminal: borrow=%b want 1", borrow);
    end
`endif
    step(1, 0, 0, 0);
    n_checks++;
    if (q !== 4'd10 || tc !== 1'b1) begin
      n_fails++;
      $display("FAIL clr_wrap: q=%0d tc=%b want q=10 tc=1", q, tc);
    end
  endtask

  task automatic test_random();
    bit xi, ldi, osi;
    int di;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_clr();
      end else begin
        xi  = ($urandom_range(0, 9) < 8);
        ldi = ($urandom_range(0, 11) == 0);
        di  = $urandom_range(0, 15);
        osi = ($urandom_range(0, 3) == 0);
        step(xi, ldi, di, osi);
      end
      n_checks++;
      if (q !== W'(m_q) || tc !== m_tc || done !== m_done || zero !== (m_q == 0)) begin
        n_fails++;
        $display("FAIL random[%0d]: q=%0d tc=%b done=%b zero=%b want q=%0d tc=%b done=%b zero=%b",
                 i, q, tc, done, zero, m_q, m_tc, m_done, (m_q == 0));
      end
`ifdef MODM_DN_BORROW_EN
      n_checks++;
      if (borrow !== (m_en && m_q == 0 && !m_done && !ld)) begin
        n_fails++;
        $display("FAIL random_borrow[%0d]: borrow=%b want %b", i, borrow,
                 (m_en && m_q == 0 && !m_done && !ld));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_clamp();
    test_oneshot();
    test_ld_priority();
    test_clr_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
